// File: rtl/usb_ctl_pkg.sv
// Shared constants and state encodings for the USB control-endpoint blocks.
package usb_ctl_pkg;

  // Default EP0 max packet sizes (full speed and high speed).
  localparam int unsigned EP0_MAX_PKT_FS = 64;
  localparam int unsigned EP0_MAX_PKT_HS = 64;

  // Width of the SETUP wLength field.
  localparam int unsigned WLEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ZLP   = 2'd3
  } ctl_state_e;

endpackage

// File: rtl/ctl_desc_packetizer_if.sv
// Byte-wide AXI4-Stream link used for both the descriptor source and the
// packet sink of the control-IN packetizer.
interface ctl_desc_packetizer_if;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tkeep;
  logic [7:0] tdata;

  modport master (output tvalid, output tlast, output tkeep, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tkeep, input tdata, output tready);
endinterface

// File: rtl/ctl_desc_packetizer.sv
// Control-IN data-stage packetizer: truncates a descriptor stream to wLength,
// splits it into MAX_PKT_SIZE packets, drains leftover source bytes and
// optionally appends a zero-length packet.
// Optional feature: define CTL_PKT_ZLP_EN to build the ZLP state.
module ctl_desc_packetizer
  import usb_ctl_pkg::*;
#(
  parameter int unsigned MAX_PKT_SIZE = EP0_MAX_PKT_HS,
  parameter int unsigned LEN_WIDTH    = WLEN_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] wlength_i,
  output logic                 busy_o,
  output logic                 done_o,
  ctl_desc_packetizer_if.slave  s_axis,
  ctl_desc_packetizer_if.master m_axis
);

  localparam int unsigned         CNT_W    = $clog2(MAX_PKT_SIZE);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_PKT_SIZE - 1);

  ctl_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic rem_one, pkt_end, beat_acc, done_c;
  logic m_valid, m_last, s_ready;
`ifdef CTL_PKT_ZLP_EN
  logic m_keep;
`endif

  assign rem_one  = (rem_q == LEN_WIDTH'(1));
  assign pkt_end  = (cnt_q == CNT_LAST);
  assign beat_acc = (state_q == ST_XFER) && s_axis.tvalid && m_axis.tready;

  // Next-state decode and stream steering for the current state.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    s_ready = 1'b0;
`ifdef CTL_PKT_ZLP_EN
    m_keep  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (wlength_i != '0) ? ST_XFER : ST_DRAIN;
      end
      ST_XFER: begin
        m_valid = s_axis.tvalid;
        s_ready = m_axis.tready;
        m_last  = s_axis.tlast | rem_one | pkt_end;
`ifdef CTL_PKT_ZLP_EN
        m_keep  = 1'b1;
`endif
        if (m_valid && m_axis.tready && m_last) begin
          if (rem_one && !s_axis.tlast) begin
            state_d = ST_DRAIN;
          end else if (s_axis.tlast) begin
`ifdef CTL_PKT_ZLP_EN
            if (pkt_end && !rem_one) begin
              state_d = ST_ZLP;
            end else begin
              state_d = ST_IDLE;
              done_c  = 1'b1;
            end
`else
            state_d = ST_IDLE;
            done_c  = 1'b1;
`endif
          end
        end
      end
      ST_DRAIN: begin
        s_ready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
`ifdef CTL_PKT_ZLP_EN
      ST_ZLP: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        if (m_axis.tready) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over every transition and suppresses completion.
    if (abort_i) begin
      state_d = ST_IDLE;
      done_c  = 1'b0;
    end
  end

  // Remaining-byte and in-packet index counters.
  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && start_i) begin
      rem_d = wlength_i;
      cnt_d = '0;
    end else if (beat_acc) begin
      rem_d = rem_q - LEN_WIDTH'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counter registers.
  // NOTE: counters are reset explicitly; only control state needs a known value, but reset also clears them to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_c & ~reset;
  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = s_axis.tdata;
`ifdef CTL_PKT_ZLP_EN
  assign m_axis.tkeep  = m_keep;
`else
  assign m_axis.tkeep  = 1'b1;
`endif

endmodule

// File: tb/tb_ctl_desc_packetizer.sv
// Self-checking bench for ctl_desc_packetizer (MAX_PKT_SIZE=64). Expected
// packet beats are pushed to a scoreboard when a transfer is started and
// popped as the DUT emits beats.
module tb_ctl_desc_packetizer;
  import usb_ctl_pkg::*;

  localparam int MAX = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       keep;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic        abort_i;
  logic [15:0] wlength_i;
  logic        busy_o;
  logic        done_o;

  ctl_desc_packetizer_if s_axis ();
  ctl_desc_packetizer_if m_axis ();

  beat_t exp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  always #5 clock = ~clock;

  ctl_desc_packetizer #(.MAX_PKT_SIZE(MAX), .LEN_WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .wlength_i (wlength_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .s_axis    (s_axis),
    .m_axis    (m_axis)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one transfer. abort_at >= 0 aborts once that many beats were accepted;
  // restart_at >= 0 pulses a stray start_i on that loop cycle.
  task automatic run_xfer(input int desc_len, input int wlen, input int ready_pct,
                          input int abort_at, input int restart_at, input logic [7:0] base);
    int    n, src_idx, acc;
    bit    finished;
    beat_t b;
    n = (wlen < desc_len) ? wlen : desc_len;
    for (int i = 0; i < n; i++) begin
      b.data = base + 8'(i);
      b.last = (i == n - 1) || ((i % MAX) == MAX - 1);
      b.keep = 1'b1;
      exp_q.push_back(b);
    end
`ifdef CTL_PKT_ZLP_EN
    if (desc_len > 0 && (desc_len % MAX) == 0 && wlen > desc_len) begin
      b.data = 8'h00;
      b.last = 1'b1;
      b.keep = 1'b0;
      exp_q.push_back(b);
    end
`endif
    @(posedge clock); #1;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b0;
    start_i       = 1'b1;
    wlength_i     = 16'(wlen);
    @(posedge clock); #1;
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1'b1);
    src_idx  = 0;
    acc      = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (abort_at >= 0 && acc == abort_at) begin
        abort_i       = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        @(negedge clock);
        check("abort_no_done", done_o, 1'b0);
        @(posedge clock); #1;
        abort_i = 1'b0;
        check("abort_busy_low", busy_o, 1'b0);
        check("abort_left_beats", exp_q.size(), n - abort_at);
        exp_q.delete();
        @(negedge clock);
        check("abort_still_no_done", done_o, 1'b0);
        return;
      end
      s_axis.tvalid = (src_idx < desc_len);
      s_axis.tdata  = base + 8'(src_idx);
      s_axis.tlast  = (src_idx == desc_len - 1);
      m_axis.tready = ($urandom_range(0, 99) < ready_pct);
      if (cyc == restart_at) begin
        start_i   = 1'b1;
        wlength_i = 16'd3;
      end
      @(negedge clock);
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          b = exp_q.pop_front();
          check("beat_last", m_axis.tlast, b.last);
          check("beat_keep", m_axis.tkeep, b.keep);
          if (b.keep) check("beat_data", m_axis.tdata, b.data);
        end
        acc++;
      end
      if (s_axis.tvalid && s_axis.tready) src_idx++;
      if (done_o) finished = 1'b1;
      @(posedge clock); #1;
      start_i = 1'b0;
    end
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b0;
    check("done_seen", finished, 1'b1);
    check("sb_empty", exp_q.size(), 0);
    check("src_consumed", src_idx, desc_len);
    check("busy_low_after_done", busy_o, 1'b0);
    @(negedge clock);
    check("done_single_pulse", done_o, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    reset         = 1'b1;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    wlength_i     = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tkeep  = 1'b1;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_s_tready", s_axis.tready, 1'b0);
    check("rst_m_tvalid", m_axis.tvalid, 1'b0);
    check("rst_m_tlast", m_axis.tlast, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_xfer(18, 64, 100, -1, -1, 8'h10);   // single short packet
    run_xfer(18, 8, 100, -1, -1, 8'h20);    // truncated, then drained
    run_xfer(128, 255, 100, -1, -1, 8'h30); // exact boundary, short of wLength
    run_xfer(128, 128, 60, -1, 10, 8'h40);  // exact fit, stalls, stray start
    run_xfer(18, 0, 100, -1, -1, 8'h50);    // wLength 0: drain only
    run_xfer(18, 18, 100, 4, -1, 8'h60);    // abort on beat 5
    run_xfer(18, 18, 100, -1, -1, 8'hA0);   // fresh transfer after abort
    run_xfer(64, 100, 50, -1, -1, 8'hC0);   // one full packet with stalls

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
